// File: rtl/fetch_unit_r32i_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetchPkgR32I : shared types and constants for the RV32I fetch unit        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fetchPkgR32I;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  typedef enum logic [0:0] {
    RUN   = ST_RUN,
    FAULT = ST_FAULT
  } FetchState;

  localparam int          INS_BYTES  = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_r32i_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetchFifoR32I : DEPTH-entry synchronous FIFO of {addr, ins} pairs         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fetchFifoR32I #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fetch_unit_r32i.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_r32i : RV32I instruction fetch with credit-limited requests    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fetch_unit_r32i
  import fetchPkgR32I::*;
#(
  parameter int               dataW     = 32,
  parameter logic [dataW-1:0] ResetAddr = dataW'(RESET_ADDR),
  parameter int               BufDepth  = 2
) (
  input  logic             clock,
  input  logic             nReset,
  output logic             memReqValid,
  input  logic             memReqReady,
  output logic [dataW-1:0] memReqAddr,
  input  logic             memRspValid,
  input  logic [dataW-1:0] memRspData,
  output logic             insValid,
  input  logic             insReady,
  output logic [dataW-1:0] rawIns,
  output logic [dataW-1:0] insAddr,
  input  logic             redirect,
  input  logic [dataW-1:0] redirectAddr,
  output logic             fetchFault
);

  localparam int               CNT_W   = $clog2(BufDepth) + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(BufDepth);
  localparam logic [dataW-1:0] STEP    = dataW'(INS_BYTES);

  logic [dataW-1:0]   fetchPC_q, fetchPC_d;
  logic [dataW-1:0]   rspPC_q, rspPC_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   dropCount_q, dropCount_d;
  FetchState          state_q, state_d;
  logic               started_q;

  logic [CNT_W-1:0]   fifoCount;
  logic               fifoEmpty, fifoFull;
  logic [2*dataW-1:0] fifoHead;
  logic [CNT_W:0]     inUse;
  logic               reqFire, rspAccept, rspDrop, rspKeep, fifoPush, fifoPop;

  // A slot freed by this cycle's pop is reusable at once, giving one word per cycle.
  assign inUse       = {1'b0, outstanding_q} + {1'b0, fifoCount} - (CNT_W+1)'(fifoPop);
  assign memReqValid = started_q && (state_q == RUN) && !redirect && (inUse < DEPTH_C);
  assign reqFire     = memReqValid && memReqReady;
  assign memReqAddr  = fetchPC_q;

  assign rspAccept = memRspValid && (outstanding_q != '0);
  assign rspDrop   = rspAccept && ((dropCount_q != '0) || redirect || (state_q != RUN));
  assign rspKeep   = rspAccept && !rspDrop;
  assign fifoPush  = rspKeep && (!fifoFull || fifoPop);

  assign insValid   = !fifoEmpty && !redirect && (state_q == RUN);
  assign fifoPop    = insValid && insReady;
  assign rawIns     = fifoHead[dataW-1:0];
  assign insAddr    = fifoHead[2*dataW-1:dataW];
  assign fetchFault = (state_q == FAULT);

  always_comb begin
    fetchPC_d     = fetchPC_q;
    rspPC_d       = rspPC_q;
    dropCount_d   = dropCount_q;
    state_d       = state_q;
    outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspAccept);
    if (reqFire) begin
      fetchPC_d = fetchPC_q + STEP;
    end
    if (rspKeep) begin
      rspPC_d = rspPC_q + STEP;
    end
    if (rspDrop && (dropCount_q != '0)) begin
      dropCount_d = dropCount_q - CNT_W'(1);
    end
    // Everything still in flight after this edge belongs to the old stream.
    if (redirect) begin
      dropCount_d = outstanding_d;
      rspPC_d     = redirectAddr;
      if (redirectAddr[1:0] == 2'b00) begin
        fetchPC_d = redirectAddr;
      end else begin
        state_d = FAULT;
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      fetchPC_q     <= ResetAddr;
      rspPC_q       <= ResetAddr;
      outstanding_q <= '0;
      dropCount_q   <= '0;
      state_q       <= RUN;
      started_q     <= 1'b0;
    end else begin
      fetchPC_q     <= fetchPC_d;
      rspPC_q       <= rspPC_d;
      outstanding_q <= outstanding_d;
      dropCount_q   <= dropCount_d;
      state_q       <= state_d;
      started_q     <= 1'b1;
    end
  end

  fetchFifoR32I #(
    .DEPTH (BufDepth),
    .WIDTH (2*dataW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (nReset),
    .push_i  (fifoPush),
    .data_i  ({rspPC_q, memRspData}),
    .pop_i   (fifoPop),
    .flush_i (redirect),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_r32i.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit_r32i : randomized bench with a stream-level fetch model     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fetch_unit_r32i;

  localparam logic [31:0] RST_ADDR = 32'hFFFF_FFF8;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        memReqReady = 1'b0;
  logic        memRspValid = 1'b0;
  logic        insReady = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] memRspData = '0;
  logic [31:0] redirectAddr = '0;
  logic        memReqValid, insValid, fetchFault;
  logic [31:0] memReqAddr, rawIns, insAddr;

  fetch_unit_r32i #(
    .dataW     (32),
    .ResetAddr (RST_ADDR),
    .BufDepth  (2)
  ) dut (
    .clock        (clock),
    .nReset       (nReset),
    .memReqValid  (memReqValid),
    .memReqReady  (memReqReady),
    .memReqAddr   (memReqAddr),
    .memRspValid  (memRspValid),
    .memRspData   (memRspData),
    .insValid     (insValid),
    .insReady     (insReady),
    .rawIns       (rawIns),
    .insAddr      (insAddr),
    .redirect     (redirect),
    .redirectAddr (redirectAddr),
    .fetchFault   (fetchFault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } ent_t;

  ent_t        q[$];
  logic [31:0] reqLog[$];
  logic [31:0] popLog[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat = 1;
  int          buffered = 0;
  bit          live = 1'b0;
  bit          fault = 1'b0;
  logic [31:0] expPC = RST_ADDR;
  logic [31:0] expInsPC = RST_ADDR;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] logAt(input logic [31:0] lg[$], input int idx);
    if (idx < lg.size()) return lg[idx];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_rsp();
    if (q.size() > 0 && q[0].due <= cyc) begin
      memRspValid = 1'b1;
      memRspData  = memf(q[0].addr);
    end else begin
      memRspValid = 1'b0;
      memRspData  = $urandom;
    end
  endtask

  // One clock: compare mid-cycle, advance the stream model, then move to the next cycle.
  task automatic step();
    bit   expReq, expIns, popNow;
    ent_t e;
    @(negedge clock);
    expIns = (buffered > 0) && !redirect && !fault;
    popNow = expIns && insReady;
    expReq = live && !fault && !redirect && (q.size() + buffered - int'(popNow) < 2);
    chk("memReqValid", 32'(memReqValid), 32'(expReq));
    chk("insValid", 32'(insValid), 32'(expIns));
    chk("fetchFault", 32'(fetchFault), 32'(fault));
    chk("memReqAddr", memReqAddr, expPC);
    if (expIns) begin
      chk("insAddr", insAddr, expInsPC);
      chk("rawIns", rawIns, memf(expInsPC));
    end
    if (memRspValid && q.size() > 0) begin
      e = q.pop_front();
      if (!redirect && !fault && e.epoch == epoch) buffered++;
    end
    if (popNow) begin
      popLog.push_back(insAddr);
      expInsPC += 32'd4;
      buffered--;
    end
    if (expReq && memReqReady) begin
      q.push_back('{addr: expPC, epoch: epoch, due: cyc + lat});
      reqLog.push_back(memReqAddr);
      expPC += 32'd4;
    end
    if (redirect) begin
      epoch++;
      buffered = 0;
      if (redirectAddr[1:0] == 2'b00) begin
        expPC    = redirectAddr;
        expInsPC = redirectAddr;
      end else begin
        fault = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    live = 1'b1;
    drive_rsp();
  endtask

  task automatic do_reset();
    nReset      = 1'b0;
    memRspValid = 1'b0;
    redirect    = 1'b0;
    q.delete();
    buffered = 0;
    fault    = 1'b0;
    live     = 1'b0;
    epoch++;
    expPC    = RST_ADDR;
    expInsPC = RST_ADDR;
    repeat (2) begin
      @(negedge clock);
      chk("rst_memReqValid", 32'(memReqValid), 32'd0);
      chk("rst_memReqAddr", memReqAddr, RST_ADDR);
      chk("rst_insValid", 32'(insValid), 32'd0);
      chk("rst_rawIns", rawIns, 32'd0);
      chk("rst_insAddr", insAddr, 32'd0);
      chk("rst_fetchFault", 32'(fetchFault), 32'd0);
      @(posedge clock);
      #1;
      cyc++;
    end
    nReset = 1'b1;
  endtask

  initial begin
    int n, m;
    do_reset();

    // Streaming with single-cycle memory: wrap past 0xFFFF_FFFC, one word per cycle.
    lat = 1; memReqReady = 1'b1; insReady = 1'b1;
    repeat (14) step();
    chk("p1_req0", logAt(reqLog, 0), 32'hFFFF_FFF8);
    chk("p1_req1", logAt(reqLog, 1), 32'hFFFF_FFFC);
    chk("p1_req2", logAt(reqLog, 2), 32'h0000_0000);
    chk("p1_req3", logAt(reqLog, 3), 32'h0000_0004);
    chk("p1_pop2", logAt(popLog, 2), 32'h0000_0000);
    chk("p1_throughput", 32'(popLog.size()), 32'd11);

    // Decoder stalled: two requests fill the buffer, then fetch resumes.
    do_reset(); reqLog.delete(); popLog.delete();
    insReady = 1'b0;
    repeat (8) step();
    chk("p2_reqs", 32'(reqLog.size()), 32'd2);
    chk("p2_reqValid_low", 32'(memReqValid), 32'd0);
    insReady = 1'b1;
    repeat (6) step();
    chk("p2_resume_req", logAt(reqLog, 2), 32'h0000_0000);
    chk("p2_pop0", logAt(popLog, 0), 32'hFFFF_FFF8);
    chk("p2_pop1", logAt(popLog, 1), 32'hFFFF_FFFC);

    // Redirect with two requests still outstanding.
    do_reset(); reqLog.delete(); popLog.delete();
    lat = 3;
    repeat (3) step();
    chk("p3_outstanding", 32'(reqLog.size()), 32'd2);
    redirect = 1'b1; redirectAddr = 32'h0000_0100;
    step();
    redirect = 1'b0; lat = 1;
    repeat (10) step();
    chk("p3_req_after", logAt(reqLog, 2), 32'h0000_0100);
    chk("p3_pop_after", logAt(popLog, 0), 32'h0000_0100);

    // Redirect during steady streaming: coincident response and pending handshake.
    repeat (4) step();
    n = reqLog.size(); m = popLog.size();
    redirect = 1'b1; redirectAddr = 32'h0000_0200;
    step();
    redirect = 1'b0;
    repeat (8) step();
    chk("p4_req_after", logAt(reqLog, n), 32'h0000_0200);
    chk("p4_pop_after", logAt(popLog, m), 32'h0000_0200);

    // Misaligned target: sticky fault, no further activity.
    redirect = 1'b1; redirectAddr = 32'h0000_0102;
    step();
    redirect = 1'b0;
    n = reqLog.size(); m = popLog.size();
    repeat (10) step();
    chk("p5_fault", 32'(fetchFault), 32'd1);
    chk("p5_no_reqs", 32'(reqLog.size()), 32'(n));
    chk("p5_no_pops", 32'(popLog.size()), 32'(m));
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      memReqReady = ($urandom_range(3) != 0);
      insReady    = ($urandom_range(3) != 0);
      lat         = $urandom_range(1, 3);
      redirect    = 1'b0;
      if (fault && $urandom_range(7) == 0) begin
        do_reset();
      end else if ($urandom_range(499) == 0) begin
        do_reset();
      end else if (live && !fault && $urandom_range(29) == 0) begin
        redirect = 1'b1;
        case ($urandom_range(9))
          0:       redirectAddr = $urandom | 32'($urandom_range(1, 3));
          1:       redirectAddr = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3));
          default: redirectAddr = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
